fphub_multiplier: RTL

- Sequential radix-2 shift-add floating-point multiplier for HUB format. It is the inverse-operation companion to the SRT divider in the FPHUB arithmetic unit.
- Same start/finish/computing handshake and same operand layout as the divider, so the two are interchangeable behind one operation selector.
- Retires one multiplier bit per cycle, then normalises, truncates (HUB round-to-nearest) and packs.

---
 rtl/fphub_pkg.sv | 40 ++++
 rtl/fphub_mul_pack.sv | 46 ++++
 rtl/fphub_multiplier.sv | 134 +++++++++++++
 3 files changed

// File: rtl/fphub_pkg.sv
// Shared FPHUB definitions: operand classes, controller states, HUB helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package fphub_pkg;

    localparam int FP_M    = 23;
    localparam int FP_E    = 8;
    localparam int FP_BIAS = (1 << (FP_E - 1)) - 1;
    localparam int FP_EMAX = (1 << FP_E) - 1;

    typedef enum logic [1:0] {
        CLS_NORMAL,
        CLS_ZERO,
        CLS_INF
    } fp_class_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_PACK
    } mul_state_e;

    // Exponent field all zeros is ZERO, all ones is INF, anything else is normal.
    function automatic fp_class_e classify(input logic [31:0] expo, input int unsigned ew);
        logic [31:0] ones;
        ones = (32'd1 << ew) - 32'd1;
        if (expo == 32'd0) begin
            return CLS_ZERO;
        end else if (expo == ones) begin
            return CLS_INF;
        end
        return CLS_NORMAL;
    endfunction

    // HUB significand {1, frac, 1}; the trailing one is the implicit LSB.
    function automatic logic [63:0] hub_mant(input logic [62:0] frac, input int unsigned mw);
        return (64'd1 << (mw + 1)) | {frac, 1'b1};
    endfunction

endpackage

// File: rtl/fphub_mul_pack.sv
// Normalise, HUB-truncate, exponent-bound and pack the raw product.
// Latency: combinational, registered by the parent.
// Backpressure: none.
module fphub_mul_pack
    import fphub_pkg::*;
#(
    parameter int M = FP_M,
    parameter int E = FP_E
) (
    input  logic [2*M+3:0]       i_p,
    input  logic signed [E+1:0]  i_e,
    input  logic                 i_s,
    output logic [M+E:0]         o_res
);

    localparam logic signed [E+1:0] EXP_SAT  = (E+2)'((1 << E) - 1);
    localparam logic signed [E+1:0] EXP_ONE  = (E+2)'(1);
    localparam logic signed [E+1:0] EXP_ZERO = (E+2)'(0);

    logic                w_top;
    logic signed [E+1:0] w_e;
    logic [M-1:0]        w_mant;
    logic                w_unused_lo;

    assign w_top = i_p[2*M+3];
    // Low product bits are discarded: truncation is the HUB rounding.
    assign w_unused_lo = ^i_p[M+1:0];

    // Pick mantissa window by product MSB, then saturate or flush on exponent range.
    always_comb begin
        w_e    = i_e;
        w_mant = i_p[2*M+1:M+2];
        if (w_top) begin
            w_e    = i_e + EXP_ONE;
            w_mant = i_p[2*M+2:M+3];
        end
        if (w_e >= EXP_SAT) begin
            o_res = {i_s, {(M+E){1'b1}}};
        end else if (w_e <= EXP_ZERO) begin
            o_res = {i_s, {(M+E){1'b0}}};
        end else begin
            o_res = {i_s, w_e[E-1:0], w_mant};
        end
    end

endmodule

// File: rtl/fphub_multiplier.sv
// Sequential radix-2 shift-add HUB floating-point multiplier.
// Latency: 1 edge for special operands, M+3 edges after accept for normal ones.
// Backpressure: start ignored while computing; held start re-issues at the pack edge.
module fphub_multiplier
    import fphub_pkg::*;
#(
    parameter int M = FP_M,
    parameter int E = FP_E
) (
    input  logic           clk,
    input  logic           rst_l,
    input  logic           start,
    input  logic [M+E:0]   x,
    input  logic [M+E:0]   y,
    output logic [M+E:0]   res,
    output logic           finish,
    output logic           computing
);

    localparam int T    = M + E;
    localparam int BIAS = (1 << (E - 1)) - 1;
    localparam int NI   = M + 2;
    localparam int PW   = 2 * M + 4;
    localparam int CW   = $clog2(NI + 1);
    localparam logic signed [E+1:0] BIAS_S = (E+2)'(BIAS);

    mul_state_e r_state, w_next;

    logic [M+1:0]        r_mx, r_my;
    logic [PW-1:0]       r_p;
    logic [CW-1:0]       r_cnt;
    logic signed [E+1:0] r_e;
    logic                r_s;
    logic [T:0]          r_res;
    logic                r_finish;
    logic                r_computing;

    fp_class_e           w_cls_x, w_cls_y;
    logic                w_special, w_any_inf, w_s, w_accept, w_last;
    logic [T:0]          w_spec_res, w_pack_res;
    logic [M+1:0]        w_mx, w_my;
    logic signed [E+1:0] w_e_sum;
    logic [PW-1:0]       w_addend;

    assign w_cls_x    = classify(32'(x[T-1:M]), E);
    assign w_cls_y    = classify(32'(y[T-1:M]), E);
    assign w_special  = (w_cls_x != CLS_NORMAL) || (w_cls_y != CLS_NORMAL);
    assign w_any_inf  = (w_cls_x == CLS_INF) || (w_cls_y == CLS_INF);
    assign w_s        = x[T] ^ y[T];
    assign w_spec_res = w_any_inf ? {w_s, {T{1'b1}}} : {w_s, {T{1'b0}}};
    assign w_mx       = (M+2)'(hub_mant(63'(x[M-1:0]), M));
    assign w_my       = (M+2)'(hub_mant(63'(y[M-1:0]), M));
    assign w_e_sum    = $signed({2'b00, x[T-1:M]}) + $signed({2'b00, y[T-1:M]}) - BIAS_S;
    // A new normal operation is taken when idle or on the pack edge (back-to-back).
    assign w_accept   = start && !w_special && (r_state != S_MUL);
    assign w_last     = (r_cnt == CW'(NI - 1));
    assign w_addend   = r_my[r_cnt] ? (PW'(r_mx) << r_cnt) : '0;

    fphub_mul_pack #(.M(M), .E(E)) u_pack (
        .i_p   (r_p),
        .i_e   (r_e),
        .i_s   (r_s),
        .o_res (w_pack_res)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state: iterate NI times, pack, then idle or chain the next request.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_MUL;
            S_MUL:   if (w_last) w_next = S_PACK;
            S_PACK:  w_next = w_accept ? S_MUL : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: operand latch, LSB-first shift-add accumulate, result register.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_mx        <= '0;
            r_my        <= '0;
            r_p         <= '0;
            r_cnt       <= '0;
            r_e         <= '0;
            r_s         <= 1'b0;
            r_res       <= '0;
            r_finish    <= 1'b0;
            r_computing <= 1'b0;
        end else begin
            r_finish <= 1'b0;
            if (w_accept) begin
                r_mx  <= w_mx;
                r_my  <= w_my;
                r_s   <= w_s;
                r_e   <= w_e_sum;
                r_p   <= '0;
                r_cnt <= '0;
            end
            case (r_state)
                S_IDLE: begin
                    if (start && w_special) begin
                        r_res    <= w_spec_res;
                        r_finish <= 1'b1;
                    end
                    if (w_accept) r_computing <= 1'b1;
                end
                S_MUL: begin
                    r_p   <= r_p + w_addend;
                    r_cnt <= r_cnt + CW'(1);
                end
                S_PACK: begin
                    r_res       <= w_pack_res;
                    r_finish    <= 1'b1;
                    r_computing <= w_accept;
                end
                default: ;
            endcase
        end
    end

    assign res       = r_res;
    assign finish    = r_finish;
    assign computing = r_computing;

endmodule
